// File: rtl/pam_loop_chan.sv
// pam_loop_chan: channel emulator placed between the PAM sender and the
// synchroniser in the loopback build. Each valid sample is taken from a
// delay line, attenuated by an arithmetic right shift, offset, optionally
// disturbed by LFSR noise, and saturated to the sample range. Latency is
// fixed at 2 cycles. Bypass turns the block back into a 2-cycle wire.
//
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   in_valid/in_data sender samples (signed), gaps allowed
//   cfg_load         pulse latching cfg_delay/shift/offset/noise_en
//   bypass           live passthrough select
//   out_valid/out_data impaired samples to the synchroniser
//   sat_cnt          saturated outputs since reset (sticks at all-ones)
module pam_loop_chan #(
    parameter int AD_CVER_WIDTH  = 12,
    parameter int DLY_ADDR_WIDTH = 7,
    parameter int NOISE_BITS     = 4,
    parameter int SAT_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      in_valid,
    input  logic [AD_CVER_WIDTH-1:0]  in_data,
    input  logic                      cfg_load,
    input  logic [DLY_ADDR_WIDTH-1:0] cfg_delay,
    input  logic [3:0]                cfg_shift,
    input  logic [AD_CVER_WIDTH-1:0]  cfg_offset,
    input  logic                      cfg_noise_en,
    input  logic                      bypass,
    output logic                      out_valid,
    output logic [AD_CVER_WIDTH-1:0]  out_data,
    output logic [SAT_CNT_WIDTH-1:0]  sat_cnt
);
    localparam int W     = AD_CVER_WIDTH;
    localparam int SW    = AD_CVER_WIDTH + 2;
    localparam int DEPTH = 2 ** DLY_ADDR_WIDTH;

    localparam logic signed [SW-1:0] MAXV = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {3'b111, {(W-1){1'b0}}};

    logic [W-1:0]              ram [DEPTH];
    logic [DLY_ADDR_WIDTH-1:0] wr_ptr, fill, delay_q;
    logic [3:0]                shift_q;
    logic [W-1:0]              offset_q;
    logic                      noise_en_q;
    logic [15:0]               lfsr;

    // A cfg_load coinciding with in_valid applies to that sample, so the
    // datapath always works from the "effective" config and fill level.
    logic [DLY_ADDR_WIDTH-1:0] delay_eff, fill_eff, fill_inc, rd_addr;
    logic [3:0]                shift_eff;
    logic [W-1:0]              offset_eff;
    logic                      noise_eff;

    assign delay_eff  = cfg_load ? cfg_delay    : delay_q;
    assign shift_eff  = cfg_load ? cfg_shift    : shift_q;
    assign offset_eff = cfg_load ? cfg_offset   : offset_q;
    assign noise_eff  = cfg_load ? cfg_noise_en : noise_en_q;
    assign fill_eff   = cfg_load ? '0           : fill;
    assign fill_inc   = (fill_eff < delay_eff) ? fill_eff + 1'b1 : fill_eff;
    assign rd_addr    = wr_ptr - delay_eff;

    logic signed [W-1:0]          delayed, atten, noise;
    logic signed [NOISE_BITS-1:0] lfsr_low;
    logic [15:0]                  lfsr_next;

    // Unfilled slots still hold stale RAM contents; mask them to zero.
    always_comb begin
        delayed = '0;
        if (delay_eff == '0)
            delayed = in_data;
        else if (fill_eff >= delay_eff)
            delayed = ram[rd_addr];
    end

    assign atten     = delayed >>> shift_eff;
    assign lfsr_low  = lfsr[NOISE_BITS-1:0];
    assign noise     = noise_eff ? W'(lfsr_low) : '0;
    // x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge clk) begin
        if (in_valid && !srst)
            ram[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr     <= '0;
            fill       <= '0;
            delay_q    <= '0;
            shift_q    <= '0;
            offset_q   <= '0;
            noise_en_q <= 1'b0;
            lfsr       <= 16'hACE1;
        end else begin
            if (cfg_load) begin
                delay_q    <= cfg_delay;
                shift_q    <= cfg_shift;
                offset_q   <= cfg_offset;
                noise_en_q <= cfg_noise_en;
                fill       <= '0;
            end
            // Later assignment wins, so load+valid leaves fill at 1.
            if (in_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
                fill   <= fill_inc;
                lfsr   <= lfsr_next;
            end
        end
    end

    // Stage 1: each sample carries its own offset and bypass flag so a
    // config change never alters samples already in flight.
    logic [2:1]          vld_pipe;
    logic                s1_bypass;
    logic [W-1:0]        s1_raw;
    logic signed [W-1:0] s1_atten, s1_noise, s1_offset;

    always_ff @(posedge clk) begin
        if (srst) begin
            vld_pipe[1] <= 1'b0;
            s1_bypass   <= 1'b0;
            s1_raw      <= '0;
            s1_atten    <= '0;
            s1_noise    <= '0;
            s1_offset   <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            if (in_valid) begin
                s1_bypass <= bypass;
                s1_raw    <= in_data;
                s1_atten  <= atten;
                s1_noise  <= noise;
                s1_offset <= offset_eff;
            end
        end
    end

    // Stage 2: widen by two bits so the three-term sum cannot wrap.
    logic signed [SW-1:0] sum;
    logic [W-1:0]         clamped;
    logic                 sat;

    assign sum = SW'(s1_atten) + SW'(s1_offset) + SW'(s1_noise);

    always_comb begin
        clamped = sum[W-1:0];
        sat     = 1'b0;
        if (sum > MAXV) begin
            clamped = MAXV[W-1:0];
            sat     = 1'b1;
        end else if (sum < MINV) begin
            clamped = MINV[W-1:0];
            sat     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            vld_pipe[2] <= 1'b0;
            out_data    <= '0;
            sat_cnt     <= '0;
        end else begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1])
                out_data <= s1_bypass ? s1_raw : clamped;
            if (vld_pipe[1] && !s1_bypass && sat && sat_cnt != '1)
                sat_cnt <= sat_cnt + 1'b1;
        end
    end

    assign out_valid = vld_pipe[2];
endmodule

// File: tb/tb_pam_loop_chan.sv
// Testbench for pam_loop_chan: directed and randomized stimulus checked
// every cycle against a sample-history reference model.
module tb_pam_loop_chan;
    localparam int W  = 12;
    localparam int DA = 7;
    localparam int NB = 4;
    localparam int SC = 16;

    logic          clk = 1'b0;
    logic          srst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          cfg_load = 1'b0;
    logic [DA-1:0] cfg_delay = '0;
    logic [3:0]    cfg_shift = '0;
    logic [W-1:0]  cfg_offset = '0;
    logic          cfg_noise_en = 1'b0;
    logic          bypass = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [SC-1:0] sat_cnt;

    pam_loop_chan #(.AD_CVER_WIDTH(W), .DLY_ADDR_WIDTH(DA), .NOISE_BITS(NB),
                    .SAT_CNT_WIDTH(SC)) dut (
        .clk(clk), .srst(srst), .in_valid(in_valid), .in_data(in_data),
        .cfg_load(cfg_load), .cfg_delay(cfg_delay), .cfg_shift(cfg_shift),
        .cfg_offset(cfg_offset), .cfg_noise_en(cfg_noise_en), .bypass(bypass),
        .out_valid(out_valid), .out_data(out_data), .sat_cnt(sat_cnt));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: history of accepted samples, config, noise state,
    // and a two-slot list of results in flight.
    int          hist[$];
    int          n_fill, m_delay, m_shift, m_off, satm;
    bit          m_noise;
    logic [15:0] m_lfsr;
    bit          p1v, p2v, p1s, p2s;
    logic [W-1:0] p1d, p2d;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        n_fill = 0; m_delay = 0; m_shift = 0; m_off = 0; m_noise = 0;
        m_lfsr = 16'hACE1; satm = 0;
        p1v = 0; p2v = 0; p1s = 0; p2s = 0; p1d = '0; p2d = '0;
    endtask

    // One clock: compute the model's view of the current inputs, take the
    // edge, then compare outputs 1 time unit later.
    task automatic cyc();
        bit nv, ns;
        logic [W-1:0] nd;
        int dl, a, nz, sum;
        nv = 0; ns = 0; nd = '0;
        if (srst) begin
            model_reset();
        end else begin
            if (cfg_load) begin
                m_delay = int'(cfg_delay); m_shift = int'(cfg_shift);
                m_off = sx(cfg_offset); m_noise = cfg_noise_en; n_fill = 0;
            end
            if (in_valid) begin
                if (m_delay == 0)          dl = sx(in_data);
                else if (n_fill < m_delay) dl = 0;
                else                       dl = hist[hist.size() - m_delay];
                hist.push_back(sx(in_data));
                if (n_fill < m_delay) n_fill++;
                a  = dl >>> m_shift;
                nz = 0;
                if (m_noise) begin
                    nz = int'(m_lfsr) % (1 << NB);
                    if (nz >= (1 << (NB - 1))) nz -= (1 << NB);
                end
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                sum = a + m_off + nz;
                if (sum > 2047)       begin sum = 2047;  ns = 1; end
                else if (sum < -2048) begin sum = -2048; ns = 1; end
                if (bypass) begin nd = in_data; ns = 0; end
                else nd = W'(sum);
                nv = 1;
            end
        end
        @(posedge clk);
        #1;
        if (!srst) begin
            p2v = p1v; p2d = p1d; p2s = p1s;
            p1v = nv;  p1d = nd;  p1s = ns;
            if (p2v && p2s && satm < 65535) satm++;
        end
        check("out_valid", int'(out_valid), int'(p2v));
        if (p2v)  check("out_data", sx(out_data), sx(p2d));
        if (srst) check("out_data_rst", int'(out_data), 0);
        check("sat_cnt", int'(sat_cnt), satm);
    endtask

    task automatic drive(input bit v, input int d);
        in_valid = v; in_data = W'(d);
        cyc();
        in_valid = 0;
    endtask

    task automatic load(input int d, input int sh, input int off, input bit ne);
        cfg_load = 1; cfg_delay = DA'(d); cfg_shift = 4'(sh);
        cfg_offset = W'(off); cfg_noise_en = ne;
        cyc();
        cfg_load = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0);
    endtask

    task automatic do_reset();
        srst = 1; cyc(); cyc(); srst = 0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Default config: plain 2-cycle wire.
        for (int i = 0; i < 20; i++) drive(1, i);
        idle(3);

        // Delay 5, continuous then gapped.
        load(5, 0, 0, 0);
        for (int i = 1; i <= 20; i++) drive(1, i);
        idle(3);
        load(5, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin drive(1, i); drive(0, 0); end
        idle(3);

        // Maximum delay across pointer wrap.
        load(127, 0, 0, 0);
        for (int i = 0; i < 300; i++) drive(1, int'($urandom_range(0, 4095)));
        idle(3);

        // Attenuation and saturation in both directions.
        load(0, 2, 0, 0);
        drive(1, -7); drive(1, 7);
        load(0, 0, 2047, 0);  drive(1, 100);
        load(0, 0, -2048, 0); drive(1, -1);
        idle(3);
        check("sat_after_clamps", int'(sat_cnt), 2);

        // Noise from a fresh LFSR; first output is sign-extended 4'h1.
        do_reset();
        load(0, 0, 0, 1);
        drive(1, 0); idle(2);
        check("first_noise", sx(out_data), 1);
        for (int i = 0; i < 20; i++) drive(1, 0);
        idle(3);

        // Bypass mid-stream over a delay-5 stream, then resume.
        load(5, 0, 0, 0);
        for (int i = 1; i <= 10; i++) drive(1, i);
        bypass = 1;
        for (int i = 11; i <= 16; i++) drive(1, i);
        bypass = 0;
        for (int i = 17; i <= 26; i++) drive(1, i);
        // Config change coinciding with a sample.
        cfg_load = 1; cfg_delay = 3; cfg_shift = 1; cfg_offset = 12'd10; cfg_noise_en = 0;
        drive(1, 500); cfg_load = 0;
        for (int i = 0; i < 8; i++) drive(1, 40 * i);

        // Saturate once, then reset mid-frame.
        load(0, 0, 2047, 0);
        drive(1, 100); drive(1, 200); drive(1, 300);
        srst = 1; in_valid = 1; in_data = 12'd9; cyc(); srst = 0; in_valid = 0;
        check("rst_sat_zero", int'(sat_cnt), 0);
        drive(1, 4); idle(3);

        // Randomized traffic with occasional config, bypass and reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                cfg_load = 1; cfg_delay = DA'($urandom); cfg_shift = 4'($urandom);
                cfg_offset = W'($urandom); cfg_noise_en = 1'($urandom);
            end
            if ($urandom_range(0, 30) == 0) bypass = ~bypass;
            srst = ($urandom_range(0, 250) == 0);
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)));
            cfg_load = 0; srst = 0;
        end
        bypass = 0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
